ripple_cla_addsub: RTL and testbench
====================================

Name: ripple_cla_addsub

Overview:
Parametrised, multi-cycle adder/subtractor built from BLK-bit carry-lookahead slices chained by a registered ripple carry. It evaluates one slice per clock, which keeps the carry path short at any WIDTH. It generalises the 8-bit en/ready adder used by the ALU datapath with:
- configurable width and slice size
- an explicit add/sub mode
- operand capture
- a status-flag set (carry, overflow, zero, negative)
- defined abort and reset behaviour

Parameters:
WIDTH, 8, operand/result width in bits; must be a multiple of BLK and at least BLK.
BLK, 4, CLA slice width in bits; NBLK = WIDTH/BLK slices, evaluated one per cycle.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous reset, active low
en  input  1  level request; a rising request in IDLE starts an operation, holding it keeps the result, dropping it aborts/clears
sub  input  1  0 = A+B, 1 = A-B (A + ~B + 1); sampled at capture
A  input  WIDTH  operand A, sampled at capture
B  input  WIDTH  operand B, sampled at capture
Output  output  WIDTH  registered result, valid while ready=1
c_out  output  1  carry out of MSB (for sub: 1 = no borrow)
ovf  output  1  two's-complement signed overflow
zero  output  1  Output == 0
neg  output  1  Output[WIDTH-1]
busy  output  1  operation in progress
ready  output  1  result and flags valid

Behaviour:
- Reset (rst_n=0, asynchronous, any state): state=IDLE; Output, c_out, ovf, zero, neg, busy and ready all 0; slice counter=0; internal carry=0.
- States are IDLE, RUN and DONE.
- IDLE:
  - On a clk edge with en=1: capture A, B^{WIDTH{sub}} and sub into registers.
  - Set carry = sub, counter = 0, busy = 1, and go to RUN.
  - Output and flags stay 0.
- RUN, each edge with en=1:
  - The CLA slice at index counter computes from the captured operands and the registered carry.
  - Write the slice sum into Output[counter*BLK +: BLK] and the slice carry into the carry register.
  - Increment the counter.
  - On the edge that writes slice NBLK-1: set c_out = final carry and compute ovf = (a_msb == b'_msb) && (sum_msb != a_msb), where b' is the inverted B for sub. Compute zero and neg from the full result. Set ready=1, busy=0, and go to DONE.
- Latency: with the capture edge counted as edge 0, ready rises at edge NBLK, i.e. after NBLK+1 edges in total.
- Input changes after capture have no effect on the result.
- DONE:
  - Hold Output and flags with ready=1 while en=1. No recompute occurs, even if A, B or sub change.
  - En=0 at an edge: go to IDLE and clear ready, Output and all flags to 0.
  - A new operation requires en to be low for at least one edge.
- Abort: en=0 at any edge in RUN → go to IDLE with busy=0, ready=0, Output and flags=0. Partial results are discarded.
- Reset mid-RUN or mid-DONE: identical to the reset state. No result is produced.
- busy and ready are never both 1. ready is never 1 in IDLE.
- Arithmetic is modulo 2^WIDTH. A - B is computed as A + ~B + 1, so c_out=1 means A ≥ B unsigned.
- Within a slice, carries are computed by generate/propagate lookahead, not bit-serial ripple. Between slices, the carry rides the registered carry only.

Test Plan:
- WIDTH=8, BLK=4, sub=0, A=100, B=27, en held high → ready=1 at edge 2 after capture; Output=127, c_out=0, ovf=0, zero=0, neg=0; busy high for exactly 2 cycles.
- WIDTH=8, sub=1, A=5, B=7 → Output=0xFE, c_out=0, ovf=0, neg=1. Separately, A=0x7F, B=0x01, sub=0 → Output=0x80, ovf=1, neg=1.
- WIDTH=8, A=0xFF, B=0x01, sub=0 → Output=0x00, c_out=1, zero=1, ovf=0. Change A/B while in RUN and DONE → result unchanged.
- WIDTH=8, start A=0x12, B=0x34, drop en one cycle after capture → next edge busy=0, ready=0, Output=0. Re-raise en with A=0x01, B=0x02 → Output=0x03 after 2 edges.
- Assert rst_n=0 asynchronously (between edges) in RUN and in DONE → all outputs 0 immediately. After release, the first operation behaves as in the first scenario.
- WIDTH=16, BLK=4, sub=1, A=0x8000, B=0x0001 → ready at edge 4; Output=0x7FFF, c_out=1, ovf=1, neg=0, zero=0.

Source files
------------

// File: rtl/ripple_cla_addsub.sv
// ripple_cla_addsub: multi-cycle adder/subtractor that evaluates one BLK-bit
// carry-lookahead slice per clock. Slices are chained through a registered
// carry. Result and status flags stay valid while ready is high.
module ripple_cla_addsub #(
    parameter int WIDTH = 8,
    parameter int BLK   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Output,
    output logic             c_out,
    output logic             ovf,
    output logic             zero,
    output logic             neg,
    output logic             busy,
    output logic             ready
);

    localparam int NBLK = WIDTH / BLK;
    localparam int CW   = (NBLK > 1) ? $clog2(NBLK) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;      // B already inverted for subtraction
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [BLK-1:0]   a_sl;
    logic [BLK-1:0]   b_sl;
    logic [BLK-1:0]   g;
    logic [BLK-1:0]   p;
    logic [BLK:0]     c;
    logic [BLK-1:0]   sum_sl;
    logic [WIDTH-1:0] res_next;
    logic             term;
    logic             c_acc;
    int               base;
    logic             last;

    // Lookahead slice: every internal carry is a flat sum of generate/propagate
    // products over the slice inputs and the registered carry-in.
    always_comb begin
        base  = int'(cnt) * BLK;
        a_sl  = a_r[base +: BLK];
        b_sl  = b_r[base +: BLK];
        g     = a_sl & b_sl;
        p     = a_sl ^ b_sl;
        c     = '0;
        c[0]  = carry;
        term  = 1'b0;
        c_acc = 1'b0;
        for (int unsigned i = 0; i < BLK; i++) begin
            term = carry;
            for (int unsigned k = 0; k <= i; k++) begin
                term = term & p[k];
            end
            c_acc = term;
            for (int unsigned j = 0; j <= i; j++) begin
                term = g[j];
                for (int unsigned k = j + 1; k <= i; k++) begin
                    term = term & p[k];
                end
                c_acc = c_acc | term;
            end
            c[i+1] = c_acc;
        end
        sum_sl = p ^ c[BLK-1:0];
        res_next = Output;
        res_next[base +: BLK] = sum_sl;
        last = (cnt == CW'(NBLK - 1));
    end

    // Control FSM with registered result, flags and handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            Output <= '0;
            c_out  <= 1'b0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
            neg    <= 1'b0;
            busy   <= 1'b0;
            ready  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (en) begin
                        a_r   <= A;
                        b_r   <= B ^ {WIDTH{sub}};
                        carry <= sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!en) begin
                        state  <= IDLE;
                        carry  <= 1'b0;
                        cnt    <= '0;
                        Output <= '0;
                        busy   <= 1'b0;
                        ready  <= 1'b0;
                    end else begin
                        Output <= res_next;
                        carry  <= c[BLK];
                        cnt    <= cnt + CW'(1);
                        if (last) begin
                            c_out <= c[BLK];
                            ovf   <= (a_r[WIDTH-1] == b_r[WIDTH-1]) &&
                                     (res_next[WIDTH-1] != a_r[WIDTH-1]);
                            zero  <= (res_next == '0);
                            neg   <= res_next[WIDTH-1];
                            ready <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (!en) begin
                        state  <= IDLE;
                        carry  <= 1'b0;
                        cnt    <= '0;
                        Output <= '0;
                        c_out  <= 1'b0;
                        ovf    <= 1'b0;
                        zero   <= 1'b0;
                        neg    <= 1'b0;
                        ready  <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ripple_cla_addsub.sv
// Self-checking bench for ripple_cla_addsub: directed table, randomized ops
// against an arithmetic reference model, abort and async-reset sequences.
module tb_ripple_cla_addsub;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en8, sub8, en16, sub16;
    logic [7:0]  a8, b8, o8;
    logic [15:0] a16, b16, o16;
    logic        c8, v8, z8, n8, bz8, rd8;
    logic        c16, v16, z16, n16, bz16, rd16;

    int n_vec = 0;
    int n_err = 0;

    ripple_cla_addsub #(.WIDTH(8), .BLK(4)) dut (
        .clk(clk), .rst_n(rst_n), .en(en8), .sub(sub8), .A(a8), .B(b8),
        .Output(o8), .c_out(c8), .ovf(v8), .zero(z8), .neg(n8),
        .busy(bz8), .ready(rd8)
    );

    ripple_cla_addsub #(.WIDTH(16), .BLK(4)) dut16 (
        .clk(clk), .rst_n(rst_n), .en(en16), .sub(sub16), .A(a16), .B(b16),
        .Output(o16), .c_out(c16), .ovf(v16), .zero(z16), .neg(n16),
        .busy(bz16), .ready(rd16)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        bit          w16;
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [15:0] r;
        logic        c, v, z, n;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic on the signed and unsigned values.
    task automatic model(input bit w16, input logic [15:0] a, input logic [15:0] b,
                         input logic s, output logic [15:0] r,
                         output logic c, output logic v, output logic z, output logic n);
        int w, ua, ub, ia, ib, exact, full;
        w  = w16 ? 16 : 8;
        ua = int'(a) & ((1 << w) - 1);
        ub = int'(b) & ((1 << w) - 1);
        ia = (ua >= (1 << (w - 1))) ? ua - (1 << w) : ua;
        ib = (ub >= (1 << (w - 1))) ? ub - (1 << w) : ub;
        if (s) begin
            full  = ua - ub;
            c     = (ua >= ub);
            exact = ia - ib;
        end else begin
            full  = ua + ub;
            c     = (full >= (1 << w));
            exact = ia + ib;
        end
        r = 16'(full & ((1 << w) - 1));
        v = (exact > (1 << (w - 1)) - 1) || (exact < -(1 << (w - 1)));
        z = (r == 16'h0);
        n = r[w-1];
    endtask

    task automatic set_in(input bit w16, input logic e, input logic s,
                          input logic [15:0] a, input logic [15:0] b);
        if (w16) begin
            en16 = e; sub16 = s; a16 = a; b16 = b;
        end else begin
            en8 = e; sub8 = s; a8 = a[7:0]; b8 = b[7:0];
        end
    endtask

    task automatic get(input bit w16, output logic [15:0] o, output logic c,
                       output logic v, output logic z, output logic n,
                       output logic bz, output logic rd);
        if (w16) begin
            o = o16; c = c16; v = v16; z = z16; n = n16; bz = bz16; rd = rd16;
        end else begin
            o = {8'h00, o8}; c = c8; v = v8; z = z8; n = n8; bz = bz8; rd = rd8;
        end
    endtask

    task automatic scramble(input bit w16);
        set_in(w16, 1'b1, 1'($urandom_range(1, 0)), 16'($urandom), 16'($urandom));
    endtask

    // Full transaction: capture, run with inputs scrambled, hold, release.
    task automatic do_op(input vec_t t);
        logic [15:0] o;
        logic        c, v, z, n, bz, rd;
        int          nblk, edges, busy_cyc;
        bit          got;
        nblk = t.w16 ? 4 : 2;
        @(negedge clk) set_in(t.w16, 1'b1, t.s, t.a, t.b);
        @(posedge clk) #1;
        get(t.w16, o, c, v, z, n, bz, rd);
        chk("cap_busy", 32'(bz), 32'd1);
        chk("cap_ready", 32'(rd), 32'd0);
        chk("cap_out", 32'(o), 32'd0);
        edges = 0;
        busy_cyc = bz ? 1 : 0;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk) scramble(t.w16);
            @(posedge clk) #1;
            edges++;
            get(t.w16, o, c, v, z, n, bz, rd);
            chk("busy_ready_excl", 32'(bz & rd), 32'd0);
            if (bz) busy_cyc++;
            if (rd) got = 1;
        end
        chk("ready_seen", 32'(got), 32'd1);
        chk("latency", 32'(edges), 32'(nblk));
        chk("busy_cycles", 32'(busy_cyc), 32'(nblk));
        chk("result", 32'(o), 32'(t.r));
        chk("c_out", 32'(c), 32'(t.c));
        chk("ovf", 32'(v), 32'(t.v));
        chk("zero", 32'(z), 32'(t.z));
        chk("neg", 32'(n), 32'(t.n));
        repeat (2) begin
            @(negedge clk) scramble(t.w16);
            @(posedge clk) #1;
            get(t.w16, o, c, v, z, n, bz, rd);
            chk("hold_result", 32'(o), 32'(t.r));
            chk("hold_flags", {28'h0, c, v, z, n}, {28'h0, t.c, t.v, t.z, t.n});
            chk("hold_ready", 32'(rd), 32'd1);
        end
        @(negedge clk) set_in(t.w16, 1'b0, 1'b0, 16'h0, 16'h0);
        @(posedge clk) #1;
        get(t.w16, o, c, v, z, n, bz, rd);
        chk("clr_ready", 32'(rd), 32'd0);
        chk("clr_busy", 32'(bz), 32'd0);
        chk("clr_out", 32'(o), 32'd0);
        chk("clr_flags", {28'h0, c, v, z, n}, 32'd0);
    endtask

    task automatic chk_all_zero(input string name);
        logic [15:0] o;
        logic        c, v, z, n, bz, rd;
        get(1'b0, o, c, v, z, n, bz, rd);
        chk(name, {o, 10'h0, c, v, z, n, bz, rd}, 32'd0);
    endtask

    vec_t tbl[8];
    vec_t rv;

    initial begin
        rst_n = 1'b0;
        set_in(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        set_in(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        #1;
        chk_all_zero("reset_state");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        //          w16   a        b        s     r        c     v     z     n
        tbl[0] = '{1'b0, 16'd100, 16'd27,  1'b0, 16'd127, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 16'd5,   16'd7,   1'b1, 16'hFE,  1'b0, 1'b0, 1'b0, 1'b1};
        tbl[2] = '{1'b0, 16'h7F,  16'h01,  1'b0, 16'h80,  1'b0, 1'b1, 1'b0, 1'b1};
        tbl[3] = '{1'b0, 16'hFF,  16'h01,  1'b0, 16'h00,  1'b1, 1'b0, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 16'h80,  16'h01,  1'b1, 16'h7F,  1'b1, 1'b1, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 16'h00,  16'h00,  1'b1, 16'h00,  1'b1, 1'b0, 1'b1, 1'b0};
        tbl[6] = '{1'b0, 16'h00,  16'h00,  1'b0, 16'h00,  1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{1'b1, 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0};
        foreach (tbl[i]) do_op(tbl[i]);

        // Abort one edge after capture, then a fresh operation.
        @(negedge clk) set_in(1'b0, 1'b1, 1'b0, 16'h12, 16'h34);
        @(posedge clk);
        @(negedge clk) en8 = 1'b0;
        @(posedge clk) #1;
        chk_all_zero("abort_clear");
        rv = '{1'b0, 16'h01, 16'h02, 1'b0, 16'h03, 1'b0, 1'b0, 1'b0, 1'b0};
        do_op(rv);

        // Asynchronous reset between edges while in RUN.
        @(negedge clk) set_in(1'b0, 1'b1, 1'b0, 16'd100, 16'd27);
        @(posedge clk) #3;
        rst_n = 1'b0;
        #1;
        chk_all_zero("reset_in_run");
        en8 = 1'b0;
        @(negedge clk) rst_n = 1'b1;

        // Asynchronous reset between edges while in DONE.
        @(negedge clk) set_in(1'b0, 1'b1, 1'b0, 16'd100, 16'd27);
        repeat (4) @(posedge clk);
        #1;
        chk("done_before_reset", 32'(rd8), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("reset_in_done");
        en8 = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        do_op(tbl[0]);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            rv.w16 = (i >= 28);
            rv.a   = 16'($urandom);
            rv.b   = 16'($urandom);
            rv.s   = 1'($urandom_range(1, 0));
            if (!rv.w16) begin
                rv.a[15:8] = 8'h00;
                rv.b[15:8] = 8'h00;
            end
            model(rv.w16, rv.a, rv.b, rv.s, rv.r, rv.c, rv.v, rv.z, rv.n);
            do_op(rv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
